// File: rtl/module_branch_predictor.sv
// rtl/module_branch_predictor.sv - BHT/BTB branch predictor with execute-stage resolution
module branch_cond_decode (
    input  logic [2:0] funct3,
    input  logic [3:0] flags,
    output logic       cond
);
    logic c_flag;
    logic v_flag;
    logic n_flag;
    logic z_flag;

    assign c_flag = flags[3];
    assign v_flag = flags[2];
    assign n_flag = flags[1];
    assign z_flag = flags[0];

    always_comb begin
        cond = 1'b0;
        case (funct3)
            3'b000:  cond = z_flag;
            3'b001:  cond = ~z_flag;
            3'b100:  cond = n_flag ^ v_flag;
            3'b101:  cond = ~(n_flag ^ v_flag);
            3'b110:  cond = ~c_flag;
            3'b111:  cond = c_flag;
            default: cond = 1'b0;
        endcase
    end
endmodule

module sat_counter #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc,
    output logic [W-1:0] count
);
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count <= '0;
        end else if (inc && (count != {W{1'b1}})) begin
            count <= count + 1'b1;
        end
    end
endmodule

module module_branch_predictor #(
    parameter int XLEN    = 32,
    parameter int ENTRIES = 64,
    parameter int IDX_W   = $clog2(ENTRIES),
    parameter int CNT_W   = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [XLEN-1:0]  PCF,
    output logic             PredTakenF,
    output logic [XLEN-1:0]  PredTargetF,
    input  logic             BranchE,
    input  logic             JumpE,
    input  logic             StallE,
    input  logic [2:0]       funct3E,
    input  logic [3:0]       Flags,
    input  logic [XLEN-1:0]  PCE,
    input  logic [XLEN-1:0]  PCTargetE,
    input  logic             PredTakenE,
    input  logic [XLEN-1:0]  PredTargetE,
    output logic             TakenE,
    output logic             MispredictE,
    output logic [XLEN-1:0]  RedirectPCE,
    output logic [CNT_W-1:0] BranchCount,
    output logic [CNT_W-1:0] MispredCount
);
    localparam int TAG_W = XLEN - IDX_W - 2;

    logic             valid_q  [ENTRIES];
    logic [1:0]       ctr_q    [ENTRIES];
    logic [TAG_W-1:0] tag_q    [ENTRIES];
    logic [XLEN-1:0]  target_q [ENTRIES];

    logic [IDX_W-1:0] f_idx;
    logic [TAG_W-1:0] f_tag;
    logic             f_hit;
    logic [IDX_W-1:0] e_idx;
    logic [TAG_W-1:0] e_tag;
    logic             e_hit;
    logic             cond;
    logic             resolve;
    logic             upd_en;
    logic             unused_pc_lsb;

    assign unused_pc_lsb = ^{PCF[1:0], PCE[1:0]};

    // Fetch lookup sees the registered table, so a same-cycle update is not visible yet
    assign f_idx       = PCF[IDX_W+1:2];
    assign f_tag       = PCF[XLEN-1:IDX_W+2];
    assign f_hit       = valid_q[f_idx] && (tag_q[f_idx] == f_tag);
    assign PredTakenF  = f_hit && ctr_q[f_idx][1];
    assign PredTargetF = PredTakenF ? target_q[f_idx] : (PCF + XLEN'(4));

    branch_cond_decode u_cond (
        .funct3 (funct3E),
        .flags  (Flags),
        .cond   (cond)
    );

    assign resolve     = BranchE | JumpE;
    assign upd_en      = resolve & ~StallE;
    assign TakenE      = JumpE | (BranchE & cond);
    assign MispredictE = resolve & ((TakenE != PredTakenE) |
                                    (TakenE & PredTakenE & (PredTargetE != PCTargetE)));
    assign RedirectPCE = TakenE ? PCTargetE : (PCE + XLEN'(4));

    assign e_idx = PCE[IDX_W+1:2];
    assign e_tag = PCE[XLEN-1:IDX_W+2];
    assign e_hit = valid_q[e_idx] && (tag_q[e_idx] == e_tag);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < ENTRIES; i++) begin
                valid_q[i] <= 1'b0;
                ctr_q[i]   <= 2'b01;
            end
        end else if (upd_en) begin
            if (e_hit) begin
                if (TakenE && (ctr_q[e_idx] != 2'b11)) begin
                    ctr_q[e_idx] <= ctr_q[e_idx] + 2'b01;
                end else if (!TakenE && (ctr_q[e_idx] != 2'b00)) begin
                    ctr_q[e_idx] <= ctr_q[e_idx] - 2'b01;
                end
            end else if (TakenE) begin
                valid_q[e_idx] <= 1'b1;
                ctr_q[e_idx]   <= 2'b10;
            end
        end
    end

    // Tag and target only matter while valid, so they carry no reset; any taken
    // resolution either allocates or refreshes the entry, and the tag is unchanged on a hit
    always_ff @(posedge clk) begin
        if (rst_n && upd_en && TakenE) begin
            tag_q[e_idx]    <= e_tag;
            target_q[e_idx] <= PCTargetE;
        end
    end

    sat_counter #(.W(CNT_W)) u_branch_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (upd_en),
        .count (BranchCount)
    );

    sat_counter #(.W(CNT_W)) u_mispred_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (upd_en & MispredictE),
        .count (MispredCount)
    );
endmodule

// File: tb/tb_module_branch_predictor.sv
// tb/tb_module_branch_predictor.sv - scoreboard bench for module_branch_predictor
module tb_module_branch_predictor;
    localparam int XLEN    = 32;
    localparam int ENTRIES = 64;
    localparam int CNT_W   = 4;
    localparam int K_PRED  = 0;
    localparam int K_RES   = 1;
    localparam int K_CNT   = 2;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [XLEN-1:0]  PCF;
    logic             PredTakenF;
    logic [XLEN-1:0]  PredTargetF;
    logic             BranchE;
    logic             JumpE;
    logic             StallE;
    logic [2:0]       funct3E;
    logic [3:0]       Flags;
    logic [XLEN-1:0]  PCE;
    logic [XLEN-1:0]  PCTargetE;
    logic             PredTakenE;
    logic [XLEN-1:0]  PredTargetE;
    logic             TakenE;
    logic             MispredictE;
    logic [XLEN-1:0]  RedirectPCE;
    logic [CNT_W-1:0] BranchCount;
    logic [CNT_W-1:0] MispredCount;

    module_branch_predictor #(
        .XLEN    (XLEN),
        .ENTRIES (ENTRIES),
        .CNT_W   (CNT_W)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .PCF          (PCF),
        .PredTakenF   (PredTakenF),
        .PredTargetF  (PredTargetF),
        .BranchE      (BranchE),
        .JumpE        (JumpE),
        .StallE       (StallE),
        .funct3E      (funct3E),
        .Flags        (Flags),
        .PCE          (PCE),
        .PCTargetE    (PCTargetE),
        .PredTakenE   (PredTakenE),
        .PredTargetE  (PredTargetE),
        .TakenE       (TakenE),
        .MispredictE  (MispredictE),
        .RedirectPCE  (RedirectPCE),
        .BranchCount  (BranchCount),
        .MispredCount (MispredCount)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          cyc;
        int          kind;
        string       name;
        logic [63:0] exp;
    } sb_t;

    sb_t sb[$];
    int  cyc      = 0;
    int  checks   = 0;
    int  failures = 0;

    sb_t         mon_e;
    logic [63:0] mon_act;
    logic [63:0] mon_exp;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        while (sb.size() > 0 && sb[0].cyc <= cyc) begin
            mon_e   = sb.pop_front();
            mon_exp = mon_e.exp;
            case (mon_e.kind)
                K_PRED:  mon_act = {31'b0, PredTakenF, PredTargetF};
                K_RES:   mon_act = {30'b0, TakenE, MispredictE, RedirectPCE};
                default: mon_act = {28'b0, BranchCount, 28'b0, MispredCount};
            endcase
            if (mon_e.kind == K_RES && !mon_exp[32]) begin
                mon_act[31:0] = '0;
                mon_exp[31:0] = '0;
            end
            checks++;
            if (mon_e.cyc != cyc || mon_act !== mon_exp) begin
                failures++;
                $display("FAIL %s: got %h expected %h (cycle %0d/%0d)",
                         mon_e.name, mon_act, mon_exp, cyc, mon_e.cyc);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        rst_n       = 1'b1;
        BranchE     = 1'b0;
        JumpE       = 1'b0;
        StallE      = 1'b0;
        funct3E     = 3'b000;
        Flags       = 4'b0000;
        PCE         = '0;
        PCTargetE   = '0;
        PredTakenE  = 1'b0;
        PredTargetE = '0;
    endtask

    task automatic push(input int kind, input string name, input logic [63:0] e);
        sb_t s;
        s.cyc  = cyc;
        s.kind = kind;
        s.name = name;
        s.exp  = e;
        sb.push_back(s);
    endtask

    task automatic probe(input logic [31:0] pc, input logic pt, input logic [31:0] tgt,
                         input string name);
        PCF = pc;
        push(K_PRED, name, {31'b0, pt, tgt});
    endtask

    task automatic cnt(input int bc, input int mc, input string name);
        push(K_CNT, name, {32'(bc), 32'(mc)});
    endtask

    task automatic resolve(input logic br, input logic jmp, input logic [2:0] f3,
                           input logic [3:0] fl, input logic [31:0] pce,
                           input logic [31:0] tgt, input logic pte, input logic [31:0] ptge,
                           input logic et, input logic em, input logic [31:0] er,
                           input string name);
        BranchE     = br;
        JumpE       = jmp;
        funct3E     = f3;
        Flags       = fl;
        PCE         = pce;
        PCTargetE   = tgt;
        PredTakenE  = pte;
        PredTargetE = ptge;
        push(K_RES, name, {30'b0, et, em, er});
    endtask

    initial begin
        rst_n = 1'b0; BranchE = 1'b0; JumpE = 1'b0; StallE = 1'b0; funct3E = 3'b000;
        Flags = 4'b0000; PCE = '0; PCTargetE = '0; PredTakenE = 1'b0; PredTargetE = '0;
        PCF = '0;
        tick();
        tick(); probe(32'h100, 0, 32'h104, "reset_pred"); cnt(0, 0, "reset_cnt");
        tick(); probe(32'h100, 0, 32'h104, "same_cycle_pre_update");
                resolve(1, 0, 3'b000, 4'b0001, 32'h100, 32'h80, 0, 32'h104, 1, 1, 32'h80, "beq_taken_mispred");
        tick(); probe(32'h100, 1, 32'h80, "bht_alloc"); cnt(1, 1, "cnt_first");
        tick(); resolve(1, 0, 3'b000, 4'b0000, 32'h100, 32'h80, 1, 32'h80, 0, 1, 32'h104, "beq_nt_mispred");
        tick(); probe(32'h100, 0, 32'h104, "ctr_01");
                resolve(1, 0, 3'b000, 4'b0000, 32'h100, 32'h80, 0, 32'h104, 0, 0, 32'h0, "beq_nt_ok1");
        tick(); resolve(1, 0, 3'b000, 4'b0000, 32'h100, 32'h80, 0, 32'h104, 0, 0, 32'h0, "beq_nt_ok2");
        tick(); probe(32'h100, 0, 32'h104, "ctr_00"); cnt(4, 2, "cnt_nt");
        tick(); resolve(1, 0, 3'b000, 4'b0001, 32'h100, 32'h80, 0, 32'h104, 1, 1, 32'h80, "beq_taken_from_00");
        tick(); probe(32'h100, 0, 32'h104, "ctr_sat_low"); cnt(5, 3, "cnt_sat_low");
                resolve(1, 0, 3'b110, 4'b0000, 32'h208, 32'h300, 0, 32'h20C, 1, 1, 32'h300, "bltu_c0");
        tick(); probe(32'h208, 1, 32'h300, "bltu_alloc");
                resolve(1, 0, 3'b111, 4'b0000, 32'h20C, 32'h340, 0, 32'h210, 0, 0, 32'h0, "bgeu_c0");
        tick(); resolve(1, 0, 3'b010, 4'b0001, 32'h210, 32'h380, 0, 32'h214, 0, 0, 32'h0, "f3_010");
        tick(); cnt(8, 4, "cnt_unsigned");
                resolve(1, 0, 3'b000, 4'b0001, 32'h100, 32'h80, 0, 32'h104, 1, 1, 32'h80, "rearm");
        tick(); probe(32'h100, 1, 32'h80, "rearmed");
        tick(); probe(32'h200, 0, 32'h204, "alias_miss");
                resolve(1, 0, 3'b000, 4'b0001, 32'h200, 32'h400, 0, 32'h204, 1, 1, 32'h400, "alias_taken");
        tick(); probe(32'h200, 1, 32'h400, "alias_realloc");
        tick(); probe(32'h100, 0, 32'h104, "alias_evicted");
                resolve(1, 0, 3'b000, 4'b0000, 32'h200, 32'h400, 1, 32'h400, 0, 1, 32'h204, "alias_nt");
        tick(); probe(32'h200, 0, 32'h204, "realloc_ctr10");
                resolve(0, 1, 3'b000, 4'b0000, 32'h208, 32'h500, 1, 32'h300, 1, 1, 32'h500, "jump_bad_target");
        tick(); probe(32'h208, 1, 32'h500, "target_rewrite");
                resolve(1, 1, 3'b000, 4'b0000, 32'h208, 32'h500, 1, 32'h500, 1, 0, 32'h0, "br_and_jump");
        tick(); StallE = 1'b1;
                resolve(1, 0, 3'b000, 4'b0001, 32'h100, 32'h600, 0, 32'h104, 1, 1, 32'h600, "stall_comb");
        tick(); probe(32'h100, 0, 32'h104, "stall_no_update"); cnt(13, 8, "stall_cnt");
        tick(); resolve(1, 0, 3'b100, 4'b0010, 32'h400, 32'h440, 0, 32'h404, 1, 1, 32'h440, "blt_n");
        tick(); resolve(1, 0, 3'b101, 4'b0010, 32'h404, 32'h440, 0, 32'h408, 0, 0, 32'h0, "bge_n");
        tick(); resolve(1, 0, 3'b100, 4'b0110, 32'h408, 32'h440, 0, 32'h40C, 0, 0, 32'h0, "blt_nv");
        tick(); resolve(1, 0, 3'b001, 4'b0000, 32'h40C, 32'h480, 1, 32'h480, 1, 0, 32'h0, "bne_pred_ok");
        tick(); cnt(15, 9, "bcnt_sat");
        for (int k = 0; k < 6; k++) begin
            tick();
            resolve(1, 0, 3'b000, 4'b0000, 32'h300, 32'h700, 1, 32'h700, 0, 1, 32'h304, "mispred_loop");
        end
        tick(); cnt(15, 15, "mcnt_full");
                resolve(1, 0, 3'b000, 4'b0000, 32'h300, 32'h700, 1, 32'h700, 0, 1, 32'h304, "mispred_extra");
        tick(); cnt(15, 15, "mcnt_sat");
        tick(); probe(32'hFFFF_FFFC, 0, 32'h0, "pcf_wrap");
                resolve(1, 0, 3'b000, 4'b0000, 32'hFFFF_FFFC, 32'h10, 1, 32'h10, 0, 1, 32'h0, "redirect_wrap");
        tick(); rst_n = 1'b0;
                resolve(0, 1, 3'b000, 4'b0000, 32'h208, 32'h900, 0, 32'h20C, 1, 1, 32'h900, "comb_in_reset");
        tick(); probe(32'h208, 0, 32'h20C, "reset_drops_update"); cnt(0, 0, "reset_cnt_clear");
        tick(); probe(32'h200, 0, 32'h204, "reset_cleared");
        tick();
        tick();
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/module_branch_predictor.md
Name: module_branch_predictor

Overview:
Parametrised successor to the execute-stage branch-condition logic. Adds full RV32I condition decode (signed and unsigned), a direct-mapped branch history table (BHT) of 2-bit saturating counters, a tagged branch target buffer (BTB), and execute-stage misprediction detection with a redirect PC. Fetch-stage lookup is combinational; the update at resolution is sequential. Saturating performance counters are included.

Parameters:
XLEN, 32, address/data width
ENTRIES, 64, BHT/BTB entries; power of two, at least 4
IDX_W, $clog2(ENTRIES), index width (derived; do not override)
CNT_W, 32, performance counter width

Ports:
clk  in  1  system clock
rst_n  in  1  synchronous reset, active-low
PCF  in  XLEN  fetch PC
PredTakenF  out  1  prediction: taken
PredTargetF  out  XLEN  predicted target; PCF+4 when not predicted taken
BranchE  in  1  conditional branch in E
JumpE  in  1  jal/jalr in E
StallE  in  1  E stage stalled; blocks update and count
funct3E  in  3  branch type
Flags  in  4  {c,v,n,z} from ALU subtract rs1-rs2; c=1 means no borrow
PCE  in  XLEN  PC of E instruction
PCTargetE  in  XLEN  computed target
PredTakenE  in  1  prediction carried from F
PredTargetE  in  XLEN  predicted target carried from F
TakenE  out  1  resolved taken
MispredictE  out  1  flush/redirect request
RedirectPCE  out  XLEN  correct next PC
BranchCount  out  CNT_W  resolved branches and jumps
MispredCount  out  CNT_W  mispredictions

Behaviour:
- Index is PC[IDX_W+1:2]. Tag is PC[XLEN-1:IDX_W+2]. Per entry: valid, tag, target, ctr[1:0].
- Condition decode (combinational):
  - 000 beq: z
  - 001 bne: ~z
  - 100 blt: n^v
  - 101 bge: ~(n^v)
  - 110 bltu: ~c
  - 111 bgeu: c
  - 010, 011: cond=0
- TakenE = JumpE | (BranchE & cond).
- Lookup (combinational from PCF):
  - hit = valid & tag match.
  - PredTakenF = hit & ctr[1].
  - PredTargetF = PredTakenF ? target : PCF+4.
- Misprediction, only when (BranchE|JumpE):
  - MispredictE = (TakenE != PredTakenE) | (TakenE & PredTakenE & PredTargetE != PCTargetE).
  - Otherwise MispredictE=0.
- RedirectPCE = TakenE ? PCTargetE : PCE+4. Valid only when MispredictE=1. PC arithmetic wraps modulo 2^XLEN.
- Update, on posedge clk when rst_n=1 & ~StallE & (BranchE|JumpE), at index of PCE:
  - If entry is a miss (invalid or tag differs) and TakenE=1: allocate valid=1, tag, target=PCTargetE, ctr=2'b10.
  - If entry is a miss and TakenE=0: no allocation; the entry is untouched.
  - If entry is a hit: ctr increments (saturate at 11) if TakenE, else decrements (saturate at 00). Target is rewritten with PCTargetE when TakenE.
  - BranchCount += 1. MispredCount += MispredictE. Both counters saturate at all-ones and do not wrap.
- A cycle with neither BranchE nor JumpE, or with StallE=1, changes no state.
- Same-cycle lookup and update of the same index: lookup returns the pre-update contents. The new value is visible the next cycle.
- Reset (rst_n=0 at posedge): all valid=0, all ctr=2'b01, both counters 0.
  - Reset overrides any same-cycle update.
  - After reset: PredTakenF=0, PredTargetF=PCF+4.
- Reset mid-stream discards all history. TakenE/MispredictE/RedirectPCE stay combinational from their inputs during reset.
- BranchE and JumpE both 1 is treated as a jump (taken).

Test Plan:
- Reset, then PCF=0x100 -> PredTakenF=0, PredTargetF=0x104, counters 0.
- Branch at PCE=0x100, funct3=000, Flags z=1, PredTakenE=0, target 0x80 -> TakenE=1, MispredictE=1, RedirectPCE=0x80. Next cycle, PCF=0x100 gives PredTakenF=1, PredTargetF=0x80. BranchCount=1, MispredCount=1.
- Same branch resolved not-taken three times -> ctr 10→01→00→00 (saturates). The first not-taken gives MispredictE=1 and RedirectPCE=0x104. PredTakenF=0 afterward.
- Unsigned: funct3=110 with c=0 -> taken. funct3=111 with c=0 -> not taken. funct3=010 with BranchE=1 -> TakenE=0.
- Aliasing: PCE=0x100 and 0x100+4*ENTRIES map to the same index. A lookup of the second PC while the first is installed gives a miss (PredTakenF=0). A taken branch at the second PC reallocates the entry with ctr=10.
- StallE=1 with BranchE=1 -> no table or counter change. Force a counter to all-ones -> it stays at all-ones after a further mispredict. rst_n=0 in the same cycle as an update -> all state cleared and the update is dropped.
